// File: rtl/mips_if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// The fetch FSM, the per-cycle fetch action and the IF/ID register layout
// live here, so the top level and the memory agree on them.
package mips_if_pkg;

    // Width of one instruction word.
    localparam int WORD_W = 32;

    // All-zero word, used as the pipeline bubble (decodes as SLL r0,r0,0).
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Byte distance between consecutive instruction words.
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    // Debug-unit controlled run state. Encoding 3 is unused and falls back
    // to LOAD.
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } if_state_t;

    // What the fetch stage does on an enabled edge in RUN. Outside RUN the
    // action is always HOLD.
    typedef enum logic [2:0] {
        ACT_HOLD   = 3'd0,
        ACT_HALT   = 3'd1,
        ACT_JUMP   = 3'd2,
        ACT_BRANCH = 3'd3,
        ACT_SEQ    = 3'd4
    } fetch_action_t;

    // IF/ID pipeline register contents handed to decode.
    typedef struct packed {
        logic [WORD_W-1:0] instruction;
        logic [WORD_W-1:0] pc_plus_4;
    } if_id_t;

    // Bubble inserted on redirects and on halt.
    localparam if_id_t IF_ID_BUBBLE = '{instruction: NOP_INSTR, pc_plus_4: 32'h0};

    // J/JAL target: upper PC nibble of the delay-free PC+4, the 26-bit
    // instruction index, then word alignment.
    function automatic logic [WORD_W-1:0] jump_target(
        input logic [WORD_W-1:0] pc_plus_4,
        input logic [WORD_W-1:0] instr
    );
        return {pc_plus_4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory for the fetch stage.
// One synchronous write port driven by the debug-unit loader and one
// asynchronous read port indexed by the PC. Contents are never reset, so a
// loaded program survives a pipeline reset.
module instruction_memory
    import mips_if_pkg::*;
#(
    parameter int IMEM_DEPTH  = 256,
    parameter int IMEM_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [IMEM_ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic [IMEM_ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0]      rd_data
);

    logic [WORD_W-1:0] mem [IMEM_DEPTH];

    // Loader write port; the caller decides when writes are legal.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Fetch reads the current word in the same cycle the PC points at it.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, the next-PC selection (sequential, branch, jump), the
// instruction memory and the IF/ID register. A LOAD/RUN/HALTED machine lets
// the debug unit load a program, start it, and observe that it stopped.
module if_stage
    import mips_if_pkg::*;
#(
    parameter int IMEM_DEPTH  = 256,
    parameter int IMEM_ADDR_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_stall,
    input  logic                   i_pc_src,
    input  logic [31:0]            i_beq_jump_dir,
    input  logic                   i_jump,
    input  logic                   i_halt,
    input  logic                   i_du_run,
    input  logic                   i_du_load_en,
    input  logic [IMEM_ADDR_W-1:0] i_du_load_addr,
    input  logic [31:0]            i_du_load_data,
    output logic [31:0]            o_instruction,
    output logic [31:0]            o_pc_plus_4,
    output logic [31:0]            o_pc,
    output logic                   o_halted,
    output logic                   o_running
);

    if_state_t     state;
    if_state_t     state_next;
    fetch_action_t action;

    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [31:0]   pc_seq;
    logic [31:0]   jump_dir;
    logic [31:0]   fetch_word;

    if_id_t        if_id;
    if_id_t        if_id_next;

    logic          imem_we;

    // PC+4 wraps naturally at 2^32 through the 32-bit adder.
    assign pc_seq   = pc + PC_STEP;

    // The jump sitting in IF/ID supplies its own target.
    assign jump_dir = jump_target(if_id.pc_plus_4, if_id.instruction);

    // The program may only be changed while the pipeline is not executing.
    assign imem_we  = (state == ST_LOAD) && i_du_load_en;

    instruction_memory #(
        .IMEM_DEPTH  (IMEM_DEPTH),
        .IMEM_ADDR_W (IMEM_ADDR_W)
    ) u_imem (
        .clk     (i_clk),
        .wr_en   (imem_we),
        .wr_addr (i_du_load_addr),
        .wr_data (i_du_load_data),
        .rd_addr (pc[IMEM_ADDR_W+1:2]),
        .rd_data (fetch_word)
    );

    // Pick this cycle's fetch action; halt outranks stall, stall masks
    // redirects whose operands are not ready, and a jump beats a branch.
    always_comb begin
        action = ACT_HOLD;
        if (state == ST_RUN) begin
            if (i_halt) begin
                action = ACT_HALT;
            end else if (i_stall) begin
                action = ACT_HOLD;
            end else if (i_jump) begin
                action = ACT_JUMP;
            end else if (i_pc_src) begin
                action = ACT_BRANCH;
            end else begin
                action = ACT_SEQ;
            end
        end
    end

    // Run-state transitions; HALTED is only left through reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: begin
                if (i_du_run) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (action == ACT_HALT) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // Next PC and IF/ID contents for the chosen action.
    always_comb begin
        pc_next    = pc;
        if_id_next = if_id;
        case (action)
            ACT_HALT: begin
                if_id_next = IF_ID_BUBBLE;
            end
            ACT_JUMP: begin
                pc_next    = jump_dir;
                if_id_next = IF_ID_BUBBLE;
            end
            ACT_BRANCH: begin
                pc_next    = i_beq_jump_dir;
                if_id_next = IF_ID_BUBBLE;
            end
            ACT_SEQ: begin
                pc_next    = pc_seq;
                if_id_next = '{instruction: fetch_word, pc_plus_4: pc_seq};
            end
            default: begin
                pc_next    = pc;
                if_id_next = if_id;
            end
        endcase
    end

    // State, PC and IF/ID registers; enable low freezes everything.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= ST_LOAD;
            pc    <= '0;
            if_id <= IF_ID_BUBBLE;
        end else if (i_enable) begin
            state <= state_next;
            pc    <= pc_next;
            if_id <= if_id_next;
        end
    end

    assign o_instruction = if_id.instruction;
    assign o_pc_plus_4   = if_id.pc_plus_4;
    assign o_pc          = pc;
    assign o_halted      = (state == ST_HALTED);
    assign o_running     = (state == ST_RUN);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for the MIPS fetch stage.
// Each stimulus cycle advances a behavioural model and queues the expected
// outputs; a separate monitor pops and compares one entry per clock.
module tb_if_stage;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        stall;
        logic        pc_src;
        logic [31:0] dir;
        logic        jump;
        logic        halt;
        logic        run;
        logic        load_en;
        logic [7:0]  addr;
        logic [31:0] data;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        halted;
        logic        running;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_stall;
    logic        i_pc_src;
    logic [31:0] i_beq_jump_dir;
    logic        i_jump;
    logic        i_halt;
    logic        i_du_run;
    logic        i_du_load_en;
    logic [7:0]  i_du_load_addr;
    logic [31:0] i_du_load_data;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus_4;
    logic [31:0] o_pc;
    logic        o_halted;
    logic        o_running;

    int n_compared = 0;
    int n_mismatch = 0;
    exp_t exp_q[$];

    // Model: 0 = loading, 1 = running, 2 = halted.
    logic [31:0] m_mem [256];
    int          m_state = 0;
    logic [31:0] m_pc = 0;
    logic [31:0] m_instr = 0;
    logic [31:0] m_pcp4 = 0;

    if_stage #(
        .IMEM_DEPTH  (256),
        .IMEM_ADDR_W (8)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_stall        (i_stall),
        .i_pc_src       (i_pc_src),
        .i_beq_jump_dir (i_beq_jump_dir),
        .i_jump         (i_jump),
        .i_halt         (i_halt),
        .i_du_run       (i_du_run),
        .i_du_load_en   (i_du_load_en),
        .i_du_load_addr (i_du_load_addr),
        .i_du_load_data (i_du_load_data),
        .o_instruction  (o_instruction),
        .o_pc_plus_4    (o_pc_plus_4),
        .o_pc           (o_pc),
        .o_halted       (o_halted),
        .o_running      (o_running)
    );

    always #5 i_clk = ~i_clk;

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst_n = 1'b1; s.en = 1'b1; s.stall = 1'b0; s.pc_src = 1'b0;
        s.dir = 32'h0; s.jump = 1'b0; s.halt = 1'b0; s.run = 1'b0;
        s.load_en = 1'b0; s.addr = 8'h0; s.data = 32'h0;
        return s;
    endfunction

    function automatic stim_t rand_stim(int st);
        stim_t s;
        s = idle_stim();
        s.rst_n  = ($urandom_range(0, 63) != 0) && !(st == 2 && $urandom_range(0, 7) == 0);
        s.en     = ($urandom_range(0, 7) != 0);
        s.stall  = ($urandom_range(0, 5) == 0);
        s.pc_src = ($urandom_range(0, 5) == 0);
        s.jump   = ($urandom_range(0, 7) == 0);
        s.halt   = ($urandom_range(0, 39) == 0);
        s.run    = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 2))
            0:       s.dir = $urandom();
            1:       s.dir = 32'hFFFF_FFF8;
            default: s.dir = $urandom() & 32'h0000_03FC;
        endcase
        s.load_en = s.rst_n && s.en && ($urandom_range(0, 1) == 1);
        s.addr    = 8'($urandom());
        s.data    = $urandom();
        return s;
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expectation.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        logic [31:0] seq;
        @(negedge i_clk);
        i_reset        = s.rst_n;
        i_enable       = s.en;
        i_stall        = s.stall;
        i_pc_src       = s.pc_src;
        i_beq_jump_dir = s.dir;
        i_jump         = s.jump;
        i_halt         = s.halt;
        i_du_run       = s.run;
        i_du_load_en   = s.load_en;
        i_du_load_addr = s.addr;
        i_du_load_data = s.data;

        if (m_state == 0 && s.load_en) m_mem[s.addr] = s.data;
        if (!s.rst_n) begin
            m_state = 0; m_pc = 0; m_instr = 0; m_pcp4 = 0;
        end else if (s.en) begin
            if (m_state == 0) begin
                if (s.run) m_state = 1;
            end else if (m_state == 1) begin
                seq = m_pc + 32'd4;
                if (s.halt) begin
                    m_instr = 0; m_pcp4 = 0; m_state = 2;
                end else if (s.stall) begin
                    // everything holds
                end else if (s.jump) begin
                    m_pc = (m_pcp4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
                    m_instr = 0; m_pcp4 = 0;
                end else if (s.pc_src) begin
                    m_pc = s.dir; m_instr = 0; m_pcp4 = 0;
                end else begin
                    m_instr = m_mem[(m_pc / 4) % 256];
                    m_pcp4  = seq;
                    m_pc    = seq;
                end
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.pcp4 = m_pcp4;
        e.halted = (m_state == 2); e.running = (m_state == 1);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the outputs after every edge that has an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pc", o_pc, e.pc);
                checkOutput("instruction", o_instruction, e.instr);
                checkOutput("pc_plus_4", o_pc_plus_4, e.pcp4);
                checkOutput("halted", {31'b0, o_halted}, {31'b0, e.halted});
                checkOutput("running", {31'b0, o_running}, {31'b0, e.running});
            end
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;

        // Reset, then load the whole memory with the sequential-fetch words first.
        s = idle_stim(); s.rst_n = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        for (int i = 0; i < 256; i++) begin
            s = idle_stim(); s.load_en = 1'b1; s.addr = 8'(i);
            s.data = (i < 4) ? 32'h1111_1111 * (i + 1) : $urandom();
            applyStimulus(s);
        end
        s = idle_stim(); s.run = 1'b1;
        applyStimulus(s);
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());

        // Stall at pc=8 with a branch request that must be ignored.
        s = idle_stim(); s.stall = 1'b1; s.pc_src = 1'b1; s.dir = 32'h20;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());

        // Branch to 0x20, then the word at index 8.
        s = idle_stim(); s.pc_src = 1'b1; s.dir = 32'h20;
        applyStimulus(s);
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());

        // Reset while running; reload word 1 with a jump and start together.
        s = idle_stim(); s.rst_n = 1'b0;
        applyStimulus(s);
        s = idle_stim(); s.load_en = 1'b1; s.addr = 8'd1; s.data = 32'h0800_0010; s.run = 1'b1;
        applyStimulus(s);
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());
        s = idle_stim(); s.jump = 1'b1; s.pc_src = 1'b1; s.dir = 32'h20;
        applyStimulus(s);
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());

        // Enable low freezes everything regardless of other requests.
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(1); s.rst_n = 1'b1; s.en = 1'b0; s.load_en = 1'b0;
            applyStimulus(s);
        end

        // Branch to 8, fetch one word, then halt at pc=12.
        s = idle_stim(); s.pc_src = 1'b1; s.dir = 32'h8;
        applyStimulus(s);
        applyStimulus(idle_stim());
        s = idle_stim(); s.halt = 1'b1;
        applyStimulus(s);
        for (int i = 0; i < 12; i++) begin
            s = rand_stim(2); s.rst_n = 1'b1; s.en = 1'b1; s.run = 1'b1;
            s.load_en = 1'b1; s.addr = 8'd0; s.data = 32'hDEAD_BEEF;
            applyStimulus(s);
        end

        // Reset and rerun: word 0 must still hold its original value.
        s = idle_stim(); s.rst_n = 1'b0;
        applyStimulus(s);
        s = idle_stim(); s.run = 1'b1;
        applyStimulus(s);
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(rand_stim(m_state));
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge i_clk);
        @(posedge i_clk);
        #2;
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatch++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
